// File: rtl/axi_pkg.sv
// Shared definitions for the stream-out path.
//   SM_ENTRY_W : width of one buffered backend beat
//   sm_beat_t  : packed beat record {data, tstrb, tkeep, user, tlast}
package axi_pkg;

    localparam int unsigned SM_ENTRY_W = 43;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  tstrb;
        logic [3:0]  tkeep;
        logic [1:0]  user;
        logic        tlast;
    } sm_beat_t;

endpackage

// File: rtl/axi_fifo.sv
// Small synchronous FIFO with registered status flags.
//   clk, rst_n      : clock, asynchronous active-low reset
//   clear           : synchronous flush (pointers and occupancy to 0)
//   wr_vld/wr_data  : write request and data; accepted when wr_rdy
//   wr_rdy          : registered, low exactly when the FIFO is full
//   rd_vld/rd_data  : registered non-empty flag and head entry
//   rd_rdy          : consumer accepts the head entry when rd_vld
module axi_fifo #(
    parameter int unsigned WIDTH = 43,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_rdy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_nxt;
    logic             full_q;
    logic             vld_q;
    logic             push;
    logic             pop;

    assign push = wr_vld && !full_q;
    assign pop  = vld_q && rd_rdy;

    always_comb begin
        count_nxt = count_q;
        if (push && !pop) begin
            count_nxt = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_nxt = count_q - (AW+1)'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else if (clear) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_nxt;
            // Flags are registered from the next occupancy so status has no
            // combinational path from the write/read strobes.
            full_q  <= (count_nxt == FULL_CNT);
            vld_q   <= (count_nxt != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !clear) begin
            mem[wptr_q] <= wr_data;
        end
    end

    assign wr_rdy  = !full_q;
    assign rd_vld  = vld_q;
    assign rd_data = mem[rptr_q];

endmodule

// File: rtl/axis_master_bk.sv
// Backend-to-AXI-Stream master stage. Buffers one-cycle beat requests from
// the bk_sm_* interface in a FIFO and presents them on the m_t* port.
//   axi_aclk, axi_aresetn : clock, asynchronous active-low reset
//   bk_sm_start, bk_sm_*  : beat request and payload
//   bk_sm_nordy           : buffer full, requester must hold off
//   bk_sm_done            : one pulse per beat accepted by the sink
//   bk_sm_err / err_clr   : sticky dropped-request flag and its clear
//   beat_cnt              : wrapping count of beats sent
//   m_t*                  : AXI-Stream master port
module axis_master_bk
    import axi_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             axi_aclk,
    input  logic             axi_aresetn,
    input  logic             bk_sm_start,
    input  logic [31:0]      bk_sm_data,
    input  logic [3:0]       bk_sm_tstrb,
    input  logic [3:0]       bk_sm_tkeep,
    input  logic [1:0]       bk_sm_user,
    input  logic             bk_sm_tlast,
    output logic             bk_sm_nordy,
    output logic             bk_sm_done,
    output logic             bk_sm_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             m_tvalid,
    output logic [31:0]      m_tdata,
    output logic [3:0]       m_tstrb,
    output logic [3:0]       m_tkeep,
    output logic [1:0]       m_tuser,
    output logic             m_tlast,
    input  logic             m_tready
);

    sm_beat_t         wr_beat;
    sm_beat_t         rd_beat;
    logic             wr_vld;
    logic             wr_rdy;
    logic             rd_vld;
    logic             handshake;
    logic             done_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        wr_beat.data  = bk_sm_data;
        wr_beat.tstrb = bk_sm_tstrb;
        wr_beat.tkeep = bk_sm_tkeep;
        wr_beat.user  = bk_sm_user;
        wr_beat.tlast = bk_sm_tlast;
    end

    assign wr_vld = bk_sm_start && !bk_sm_nordy;

    axi_fifo #(
        .WIDTH (SM_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (axi_aclk),
        .rst_n   (axi_aresetn),
        .clear   (1'b0),
        .wr_vld  (wr_vld),
        .wr_data (wr_beat),
        .wr_rdy  (wr_rdy),
        .rd_vld  (rd_vld),
        .rd_data (rd_beat),
        .rd_rdy  (m_tready)
    );

    assign bk_sm_nordy = !wr_rdy;
    assign handshake   = rd_vld && m_tready;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= handshake;
            if (handshake) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // A dropped request takes priority over a clear in the same cycle.
            if (bk_sm_start && bk_sm_nordy) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bk_sm_done = done_q;
    assign bk_sm_err  = err_q;
    assign beat_cnt   = cnt_q;

    assign m_tvalid = rd_vld;
    assign m_tdata  = rd_beat.data;
    assign m_tstrb  = rd_beat.tstrb;
    assign m_tkeep  = rd_beat.tkeep;
    assign m_tuser  = rd_beat.user;
    assign m_tlast  = rd_beat.tlast;

endmodule

// File: tb/tb_axis_master_bk.sv
// Bench for axis_master_bk: a directed vector table, randomized traffic
// against a queue-based reference, and hand-written corner sequences.
// A second instance with a 4-bit counter shares all inputs.
module tb_axis_master_bk;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] data = '0;
    logic [3:0]  strb = '0;
    logic [3:0]  keep = '0;
    logic [1:0]  user = '0;
    logic        last = 1'b0;
    logic        clr = 1'b0;
    logic        ready = 1'b0;

    logic        nordy, done, err, tvalid, tlast;
    logic [15:0] cnt;
    logic [31:0] tdata;
    logic [3:0]  tstrb, tkeep;
    logic [1:0]  tuser;

    logic        nordy4, done4, err4, tvalid4, tlast4;
    logic [3:0]  cnt4;
    logic [31:0] tdata4;
    logic [3:0]  tstrb4, tkeep4;
    logic [1:0]  tuser4;

    always #5 clk = ~clk;

    axis_master_bk #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .bk_sm_start(start), .bk_sm_data(data), .bk_sm_tstrb(strb),
        .bk_sm_tkeep(keep), .bk_sm_user(user), .bk_sm_tlast(last),
        .bk_sm_nordy(nordy), .bk_sm_done(done), .bk_sm_err(err),
        .err_clr(clr), .beat_cnt(cnt),
        .m_tvalid(tvalid), .m_tdata(tdata), .m_tstrb(tstrb), .m_tkeep(tkeep),
        .m_tuser(tuser), .m_tlast(tlast), .m_tready(ready)
    );

    axis_master_bk #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .bk_sm_start(start), .bk_sm_data(data), .bk_sm_tstrb(strb),
        .bk_sm_tkeep(keep), .bk_sm_user(user), .bk_sm_tlast(last),
        .bk_sm_nordy(nordy4), .bk_sm_done(done4), .bk_sm_err(err4),
        .err_clr(clr), .beat_cnt(cnt4),
        .m_tvalid(tvalid4), .m_tdata(tdata4), .m_tstrb(tstrb4), .m_tkeep(tkeep4),
        .m_tuser(tuser4), .m_tlast(tlast4), .m_tready(ready)
    );

    int total = 0;
    int bad = 0;

    // Reference model: the buffer is a queue of beats.
    logic [42:0] q[$];
    int unsigned m_cnt = 0;
    logic        m_err = 1'b0;
    logic        m_done = 1'b0;

    typedef struct {
        logic        start;
        logic [42:0] beat;
        logic        ready;
        logic        clr;
        logic        e_tv;
        logic [31:0] e_data;
        logic        e_nordy;
        logic        e_done;
        logic        e_err;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [42:0] mkbeat(input logic [31:0] d);
        return {d, 4'hF, 4'hF, 2'd0, 1'b0};
    endfunction

    function automatic vec_t mkvec(input logic s, input logic [42:0] b, input logic r,
                                   input logic c, input logic tv, input logic [31:0] ed,
                                   input logic en, input logic edn, input logic ee,
                                   input logic [15:0] ec);
        vec_t v;
        v.start = s; v.beat = b; v.ready = r; v.clr = c;
        v.e_tv = tv; v.e_data = ed; v.e_nordy = en; v.e_done = edn;
        v.e_err = ee; v.e_cnt = ec;
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_cnt = 0;
        m_err = 1'b0;
        m_done = 1'b0;
    endtask

    // One clock edge of the reference, evaluated on pre-edge state.
    task automatic model_edge(input logic s, input logic [42:0] b, input logic r, input logic c);
        bit full;
        bit pop;
        full = (q.size() == DEPTH);
        pop = (q.size() != 0) && r;
        m_done = pop;
        if (pop) m_cnt++;
        if (s && full) m_err = 1'b1;
        else if (c) m_err = 1'b0;
        if (pop) void'(q.pop_front());
        if (s && !full) q.push_back(b);
    endtask

    task automatic check_model();
        logic exp_tv;
        exp_tv = (q.size() != 0);
        check("tvalid", {63'd0, tvalid}, {63'd0, exp_tv});
        check("tvalid4", {63'd0, tvalid4}, {63'd0, exp_tv});
        if (exp_tv) begin
            check("payload", {21'd0, tdata, tstrb, tkeep, tuser, tlast}, {21'd0, q[0]});
            check("payload4", {21'd0, tdata4, tstrb4, tkeep4, tuser4, tlast4}, {21'd0, q[0]});
        end
        check("nordy", {63'd0, nordy}, {63'd0, q.size() == DEPTH});
        check("nordy4", {63'd0, nordy4}, {63'd0, q.size() == DEPTH});
        check("done", {63'd0, done}, {63'd0, m_done});
        check("done4", {63'd0, done4}, {63'd0, m_done});
        check("err", {63'd0, err}, {63'd0, m_err});
        check("err4", {63'd0, err4}, {63'd0, m_err});
        check("cnt", {48'd0, cnt}, {48'd0, m_cnt[15:0]});
        check("cnt4", {60'd0, cnt4}, {60'd0, m_cnt[3:0]});
    endtask

    task automatic apply(input logic s, input logic [42:0] b, input logic r, input logic c);
        start = s;
        {data, strb, keep, user, last} = b;
        ready = r;
        clr = c;
        @(posedge clk);
        model_edge(s, b, r, c);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        start = 1'b0; ready = 1'b0; clr = 1'b0;
        {data, strb, keep, user, last} = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int done_cnt;
        int run;
        int max_run;
        logic [42:0] rb;

        // Single beat, then fill/overflow/drain with simultaneous set/clear.
        vecs[0]  = mkvec(1, {32'hDEADBEEF, 4'hF, 4'hF, 2'd2, 1'b1}, 1, 0, 1, 32'hDEADBEEF, 0, 0, 0, 16'd0);
        vecs[1]  = mkvec(0, '0, 1, 0, 0, 32'h0, 0, 1, 0, 16'd1);
        vecs[2]  = mkvec(0, '0, 1, 0, 0, 32'h0, 0, 0, 0, 16'd1);
        vecs[3]  = mkvec(1, mkbeat(32'hA1), 0, 0, 1, 32'hA1, 0, 0, 0, 16'd1);
        vecs[4]  = mkvec(1, mkbeat(32'hA2), 0, 0, 1, 32'hA1, 0, 0, 0, 16'd1);
        vecs[5]  = mkvec(1, mkbeat(32'hA3), 0, 0, 1, 32'hA1, 0, 0, 0, 16'd1);
        vecs[6]  = mkvec(1, mkbeat(32'hA4), 0, 0, 1, 32'hA1, 1, 0, 0, 16'd1);
        vecs[7]  = mkvec(1, mkbeat(32'hA5), 0, 0, 1, 32'hA1, 1, 0, 1, 16'd1);
        vecs[8]  = mkvec(1, mkbeat(32'hA6), 0, 1, 1, 32'hA1, 1, 0, 1, 16'd1);
        vecs[9]  = mkvec(0, '0, 0, 1, 1, 32'hA1, 1, 0, 0, 16'd1);
        vecs[10] = mkvec(1, mkbeat(32'hB0), 1, 0, 1, 32'hA2, 0, 1, 1, 16'd2);
        vecs[11] = mkvec(0, '0, 1, 1, 1, 32'hA3, 0, 1, 0, 16'd3);
        vecs[12] = mkvec(0, '0, 1, 0, 1, 32'hA4, 0, 1, 0, 16'd4);
        vecs[13] = mkvec(0, '0, 1, 0, 0, 32'h0, 0, 1, 0, 16'd5);
        vecs[14] = mkvec(0, '0, 1, 0, 0, 32'h0, 0, 0, 0, 16'd5);

        do_reset();
        #1;
        check("rst_tvalid", {63'd0, tvalid}, 64'd0);
        check("rst_payload", {21'd0, tdata, tstrb, tkeep, tuser, tlast}, 64'd0);
        check("rst_nordy", {63'd0, nordy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_cnt", {48'd0, cnt}, 64'd0);

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].start, vecs[i].beat, vecs[i].ready, vecs[i].clr);
            check($sformatf("tbl%0d_tvalid", i), {63'd0, tvalid}, {63'd0, vecs[i].e_tv});
            if (vecs[i].e_tv)
                check($sformatf("tbl%0d_data", i), {32'd0, tdata}, {32'd0, vecs[i].e_data});
            check($sformatf("tbl%0d_nordy", i), {63'd0, nordy}, {63'd0, vecs[i].e_nordy});
            check($sformatf("tbl%0d_done", i), {63'd0, done}, {63'd0, vecs[i].e_done});
            check($sformatf("tbl%0d_err", i), {63'd0, err}, {63'd0, vecs[i].e_err});
            check($sformatf("tbl%0d_cnt", i), {48'd0, cnt}, {48'd0, vecs[i].e_cnt});
        end

        // Randomized traffic: low-ready phase to hit full, then balanced.
        for (int i = 0; i < 600; i++) begin
            rb = {$urandom(), 4'($urandom()), 4'($urandom()), 2'($urandom()), 1'($urandom())};
            apply($urandom_range(0, 99) < 60, rb,
                  $urandom_range(0, 99) < ((i < 300) ? 30 : 70),
                  $urandom_range(0, 99) < 5);
        end

        // Stall with three beats buffered; head must hold steady.
        do_reset();
        apply(1, mkbeat(32'h1), 0, 0);
        apply(1, mkbeat(32'h2), 0, 0);
        apply(1, mkbeat(32'h3), 0, 0);
        for (int i = 0; i < 10; i++) begin
            apply(0, '0, 0, 0);
            check("stall_tvalid", {63'd0, tvalid}, 64'd1);
            check("stall_data", {32'd0, tdata}, 64'h1);
        end
        apply(0, '0, 1, 0);
        check("drain_data2", {32'd0, tdata}, 64'h2);
        apply(0, '0, 1, 0);
        check("drain_data3", {32'd0, tdata}, 64'h3);
        apply(0, '0, 1, 0);
        check("drain_empty", {63'd0, tvalid}, 64'd0);

        // Throughput: 100 back-to-back starts with ready held high.
        do_reset();
        done_cnt = 0; run = 0; max_run = 0;
        for (int i = 0; i < 102; i++) begin
            apply(i < 100, mkbeat(32'(i)), 1, 0);
            check("tput_nordy", {63'd0, nordy}, 64'd0);
            if (done) begin
                done_cnt++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        check("tput_done_cnt", 64'(done_cnt), 64'd100);
        check("tput_done_run", 64'(max_run), 64'd100);
        check("tput_cnt", {48'd0, cnt}, 64'd100);

        // Counter wrap on the 4-bit instance.
        do_reset();
        for (int i = 0; i < 17; i++) apply(1, mkbeat(32'(i + 16'h100)), 1, 0);
        apply(0, '0, 1, 0);
        check("wrap_cnt4", {60'd0, cnt4}, 64'd1);
        check("wrap_cnt", {48'd0, cnt}, 64'd17);

        // Asynchronous reset mid-stream with three beats buffered.
        apply(1, mkbeat(32'hC1), 0, 0);
        apply(1, mkbeat(32'hC2), 0, 0);
        apply(1, mkbeat(32'hC3), 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_tvalid", {63'd0, tvalid}, 64'd0);
        check("arst_cnt", {48'd0, cnt}, 64'd0);
        check("arst_nordy", {63'd0, nordy}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply(0, '0, 1, 0);
            check("arst_after_tvalid", {63'd0, tvalid}, 64'd0);
            check("arst_after_done", {63'd0, done}, 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
